// File: rtl/alu_ctrl_md_pkg.sv
// Shared constants for the ALU control / mult-div block: ALU op codes,
// funct field values, main-decoder classes and the mult/div state type.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_PASS = 4'd15;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [1:0] ALU_CTR_ADD   = 2'b00;
  localparam logic [1:0] ALU_CTR_SUB   = 2'b01;
  localparam logic [1:0] ALU_CTR_RTYPE = 2'b10;
  localparam logic [1:0] ALU_CTR_OR    = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_t;

  // addu/subu share the signed opcode; the ALU does not trap on overflow here.
  function automatic logic [3:0] decode_alu_op(input logic [1:0] alu_ctr,
                                               input logic [5:0] func);
    logic [3:0] op;
    op = ALU_PASS;
    case (alu_ctr)
      ALU_CTR_ADD: op = ALU_ADD;
      ALU_CTR_SUB: op = ALU_SUB;
      ALU_CTR_OR:  op = ALU_OR;
      default: begin
        casez (func)
          6'b10000?: op = ALU_ADD;
          6'b10001?: op = ALU_SUB;
          FN_AND:    op = ALU_AND;
          FN_OR:     op = ALU_OR;
          FN_XOR:    op = ALU_XOR;
          FN_NOR:    op = ALU_NOR;
          FN_SLT:    op = ALU_SLT;
          FN_SLTU:   op = ALU_SLTU;
          FN_SLL:    op = ALU_SLL;
          FN_SRL:    op = ALU_SRL;
          FN_SRA:    op = ALU_SRA;
          default:   op = ALU_PASS;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_md_if.sv
// EX-stage bundle between the pipeline (master) and the ALU control block (slave).
interface alu_ctrl_md_if #(parameter int WIDTH = 32);
  logic [1:0]       alu_ctr;
  logic [5:0]       func;
  logic             ex_valid;
  logic             md_kill;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [3:0]       alu_op;
  logic             md_busy;
  logic             md_stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output alu_ctr, func, ex_valid, md_kill, rs_val, rt_val,
    input  alu_op, md_busy, md_stall, hi, lo
  );

  modport slave (
    input  alu_ctr, func, ex_valid, md_kill, rs_val, rt_val,
    output alu_op, md_busy, md_stall, hi, lo
  );
endinterface

// File: rtl/alu_ctrl_md_iter_core.sv
// Iterative mult/div engine: one shift-add or restoring shift-subtract step per
// cycle on operand magnitudes, sign fix in the final state.
//
// state | meaning
// IDLE  | waiting for start; operands sampled on accept
// CALC  | WIDTH iteration steps, counter runs WIDTH..1
// FIX   | results presented with sign correction; done on the closing edge
module md_iter_core
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  md_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, q, b;
  logic div_q, neg_q, neg_r, div0;

  logic             accept;
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign accept = (state == IDLE) & start & ~kill;
  assign a_neg  = is_signed & op_a[WIDTH-1];
  assign b_neg  = is_signed & op_b[WIDTH-1];
  assign a_mag  = a_neg ? -op_a : op_a;
  assign b_mag  = b_neg ? -op_b : op_b;
  assign b_zero = (op_b == '0);

  assign mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
  assign div_sh   = {acc, q[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, b});
  // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
  assign div_diff = div_sh[WIDTH-1:0] - b;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; kill wins over every transition out of IDLE and into FIX.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (kill) state_nxt = IDLE;
               else if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, then one iteration step per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      q     <= '0;
      b     <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
    end else if (accept) begin
      cnt   <= CNT_W'(WIDTH);
      acc   <= '0;
      // Divide by zero keeps the raw dividend so it shifts through into the remainder.
      q     <= (is_div & b_zero) ? op_a : a_mag;
      b     <= b_mag;
      div_q <= is_div;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      div0  <= is_div & b_zero;
    end else if (state == CALC) begin
      cnt <= cnt - 1'b1;
      if (div_q) begin
        acc <= div_ge ? div_diff : div_sh[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], div_ge};
      end else begin
        acc <= mul_sum[WIDTH:1];
        q   <= {mul_sum[0], q[WIDTH-1:1]};
      end
    end
  end

  // Sign correction of the finished magnitudes.
  always_comb begin
    prod   = {acc, q};
    prod_s = neg_q ? -prod : prod;
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (div_q) begin
      res_lo = (neg_q & ~div0) ? -q : q;
      res_hi = (neg_r & ~div0) ? -acc : acc;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FIX) & ~kill;

endmodule

// File: rtl/alu_ctrl_md.sv
// EX-stage ALU control: funct decode, HI/LO registers and stall generation
// around the iterative mult/div core.
module alu_ctrl_md
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic          clk,
  input logic          rst_n,
  alu_ctrl_md_if.slave bus
);

  logic is_rtype, is_md_start, is_md_move;
  logic md_start, wr_mthi, wr_mtlo;
  logic core_busy, core_done;
  logic [WIDTH-1:0] res_hi, res_lo, hi_q, lo_q;

  assign is_rtype    = (bus.alu_ctr == ALU_CTR_RTYPE);
  assign is_md_start = is_rtype & (bus.func[5:2] == 4'b0110);
  assign is_md_move  = is_rtype & (bus.func[5:2] == 4'b0100);

  assign md_start = bus.ex_valid & is_md_start & ~core_busy & ~bus.md_kill;
  assign wr_mthi  = bus.ex_valid & ~core_busy & ~bus.md_kill & is_rtype & (bus.func == FN_MTHI);
  assign wr_mtlo  = bus.ex_valid & ~core_busy & ~bus.md_kill & is_rtype & (bus.func == FN_MTLO);

  md_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (md_start),
    .kill      (bus.md_kill),
    .is_div    (bus.func[1]),
    .is_signed (~bus.func[0]),
    .op_a      (bus.rs_val),
    .op_b      (bus.rt_val),
    .busy      (core_busy),
    .done      (core_done),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // HI/LO update: engine results on completion, otherwise mthi/mtlo moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (core_done) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else begin
      if (wr_mthi) hi_q <= bus.rs_val;
      if (wr_mtlo) lo_q <= bus.rs_val;
    end
  end

  assign bus.alu_op   = decode_alu_op(bus.alu_ctr, bus.func);
  assign bus.md_busy  = core_busy;
  assign bus.md_stall = bus.ex_valid & core_busy & (is_md_start | is_md_move);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench for alu_ctrl_md: decode table, mult/div results and latency,
// stall behaviour, kill and asynchronous reset.
module tb_alu_ctrl_md;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_md_if #(.WIDTH(WIDTH)) bus ();
  alu_ctrl_md #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hand-written decode table, indexed by the full funct value.
  function automatic logic [3:0] ref_rtype(input int f);
    case (f)
      32, 33:  return 4'd0;
      34, 35:  return 4'd1;
      36:      return 4'd2;
      37:      return 4'd3;
      38:      return 4'd4;
      39:      return 4'd5;
      42:      return 4'd6;
      43:      return 4'd7;
      0:       return 4'd8;
      2:       return 4'd9;
      3:       return 4'd10;
      default: return 4'd15;
    endcase
  endfunction

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.md_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    bus.alu_ctr  = 2'b10;
    bus.func     = fn;
    bus.rs_val   = a;
    bus.rt_val   = b;
    bus.ex_valid = 1'b1;
  endtask

  task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    @(negedge clk);
    issue(fn, a, b);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    bus.func     = 6'b100000;
    bus.rs_val   = ~a;
    bus.rt_val   = ~b;
    wait_idle(n);
    chk({tag, "_cycles"}, 64'(n), 64'd33);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(elo));
  endtask

  initial begin
    int n;
    int stall_bad;
    bus.alu_ctr  = 2'b00;
    bus.func     = 6'd0;
    bus.ex_valid = 1'b0;
    bus.md_kill  = 1'b0;
    bus.rs_val   = '0;
    bus.rt_val   = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_busy", 64'(bus.md_busy), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_stall", 64'(bus.md_stall), 64'd0);
    chk("rst_alu_op", 64'(bus.alu_op), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep; ex_valid is low so nothing is started.
    for (int f = 0; f < 64; f++) begin
      bus.alu_ctr = 2'b10;
      bus.func    = 6'(f);
      #1;
      chk($sformatf("decode_f%0d", f), 64'(bus.alu_op), 64'(ref_rtype(f)));
    end
    bus.func = 6'b101011; bus.alu_ctr = 2'b00; #1 chk("decode_ctr00", 64'(bus.alu_op), 64'd0);
    bus.alu_ctr = 2'b01; #1 chk("decode_ctr01", 64'(bus.alu_op), 64'd1);
    bus.alu_ctr = 2'b11; #1 chk("decode_ctr11", 64'(bus.alu_op), 64'd3);
    bus.alu_ctr = 2'b00; bus.func = 6'b000000;

    run_md("multu_max", 6'b011001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
    run_md("mult_neg",  6'b011000, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("div_neg",   6'b011010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu_zero", 6'b011011, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
    run_md("div_ovf",   6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_md("divu_big",  6'b011011, 32'hFFFF_FFF9, 32'h0000_0010, 32'h0000_0009, 32'h0FFF_FFFF);

    // mflo issued 5 cycles after a mult stalls until busy falls.
    @(negedge clk);
    issue(6'b011000, 32'd2, 32'd3);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    repeat (4) @(negedge clk);
    issue(6'b010010, 32'd0, 32'd0);
    #1;
    stall_bad = 0;
    n = 0;
    while (bus.md_busy && n < 200) begin
      if (!bus.md_stall) stall_bad++;
      n++;
      @(negedge clk);
    end
    chk("mflo_stall_held", 64'(stall_bad), 64'd0);
    chk("mflo_stall_len", 64'(n), 64'd29);
    chk("mflo_stall_release", 64'(bus.md_stall), 64'd0);
    chk("mult_small_lo", 64'(bus.lo), 64'd6);
    bus.ex_valid = 1'b0;

    // A second mult while busy is stalled and never accepted.
    @(negedge clk);
    issue(6'b011000, 32'd4, 32'd5);
    @(negedge clk);
    bus.func = 6'b100000;
    #1 chk("add_no_stall", 64'(bus.md_stall), 64'd0);
    @(negedge clk);
    issue(6'b011001, 32'd7, 32'd7);
    #1 chk("mult2_stall", 64'(bus.md_stall), 64'd1);
    repeat (3) @(negedge clk);
    bus.ex_valid = 1'b0;
    wait_idle(n);
    chk("mult2_hi", 64'(bus.hi), 64'd0);
    chk("mult2_lo", 64'(bus.lo), 64'd20);
    @(negedge clk);
    chk("mult2_not_taken", 64'(bus.md_busy), 64'd0);

    // mthi/mtlo, kill overriding moves and starts, kill during CALC.
    issue(6'b010001, 32'h1234, 32'd0);
    @(negedge clk);
    issue(6'b010011, 32'h5678, 32'd0);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    chk("mthi", 64'(bus.hi), 64'h1234);
    chk("mtlo", 64'(bus.lo), 64'h5678);
    issue(6'b010001, 32'hDEAD, 32'd0);
    bus.md_kill = 1'b1;
    @(negedge clk);
    chk("kill_mthi", 64'(bus.hi), 64'h1234);
    issue(6'b011000, 32'd5, 32'd5);
    @(negedge clk);
    chk("kill_start", 64'(bus.md_busy), 64'd0);
    bus.md_kill = 1'b0;
    issue(6'b011000, 32'd5, 32'd5);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("kill_busy_before", 64'(bus.md_busy), 64'd1);
    bus.md_kill = 1'b1;
    @(negedge clk);
    bus.md_kill = 1'b0;
    chk("kill_busy", 64'(bus.md_busy), 64'd0);
    chk("kill_hi", 64'(bus.hi), 64'h1234);
    chk("kill_lo", 64'(bus.lo), 64'h5678);
    repeat (40) @(negedge clk);
    chk("kill_stays_idle", 64'(bus.md_busy), 64'd0);
    chk("kill_lo_late", 64'(bus.lo), 64'h5678);

    // Asynchronous reset mid-operation.
    issue(6'b011001, 32'd3, 32'd3);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.md_busy), 64'd0);
    chk("arst_hi", 64'(bus.hi), 64'd0);
    chk("arst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle", 64'(bus.md_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_md.md
Name: alu_ctrl_md

Overview:
- Next-generation ALU control for the MIPS datapath, parametrised in data width.
- Decodes `alu_ctr` and R-type `func` into a widened 4-bit ALU operation code. It also owns an iterative multiply/divide engine with HI/LO registers.
- Sits in the EX stage beside the ALU. It raises a stall to the pipeline controller while a multiply/divide is in flight and a dependent HI/LO instruction arrives.

Parameters:
- `WIDTH`, 32, operand, HI and LO width. Must be even and ≥ 8.
- `CNT_W`, $clog2(WIDTH)+1, iteration counter width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `alu_ctr`  in  2  main-decoder ALU class: 00 add, 01 sub, 10 R-type (use `func`), 11 or.
- `func`  in  6  instruction funct field.
- `ex_valid`  in  1  EX stage holds a valid instruction this cycle.
- `md_kill`  in  1  abort any in-flight mult/div (exception/flush).
- `rs_val`  in  WIDTH  source operand A / dividend.
- `rt_val`  in  WIDTH  source operand B / divisor.
- `alu_op`  out  4  ALU operation code (combinational).
- `md_busy`  out  1  engine not idle.
- `md_stall`  out  1  stall request to pipeline.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

Behaviour:
- Reset: asynchronous, active-low, single clock `clk`. State=IDLE, counter=0, `hi`=0, `lo`=0, `md_busy`=0. `md_stall` and `alu_op` follow their combinational inputs.
- `alu_op` codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 15 PASS (non-ALU).
- `alu_ctr` 00→ADD, 01→SUB, 11→OR.
- `alu_ctr` 10, by `func`:
  - 10000x→ADD, 10001x→SUB, 100100→AND, 100101→OR, 100110→XOR, 100111→NOR.
  - 101010→SLT, 101011→SLTU, 000000→SLL, 000010→SRL, 000011→SRA.
  - All else→PASS.
- md classes (only when `alu_ctr`=10):
  - mult 011000, multu 011001, div 011010, divu 011011.
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- Accept: start = `ex_valid` & md-start-class & ~`md_busy` & ~`md_kill`. On that edge, latch operands, take magnitudes if signed, record result signs, counter=`WIDTH`, go to CALC.
- CALC: one shift-add (mult) or restoring shift-subtract (div) step per cycle. Counter decrements each cycle; on the step where counter reaches 1, go to FIX. CALC lasts exactly `WIDTH` cycles.
- FIX: apply sign correction and write HI/LO on the closing edge, then go to IDLE.
  - mult: {hi,lo} = 2·WIDTH-bit product.
  - div: lo = quotient, hi = remainder; remainder sign = dividend sign.
- Timing: `md_busy` = (state≠IDLE). It is high for exactly `WIDTH`+1 cycles. The new HI/LO value and `md_busy`=0 appear after the same edge.
- `md_stall` = `ex_valid` & `md_busy` & (any md class, including a new mult/div). It is combinational, with no added latency.
- mthi/mtlo: when `ex_valid` & ~`md_busy`, write `rs_val` to hi/lo on the edge. They are never accepted while busy (stalled instead).
- Divide by zero: runs full latency. Result lo = all ones, hi = `rs_val` as latched; no sign fix.
- Signed overflow (MIN / −1): lo = MIN, hi = 0. This falls out of magnitude arithmetic.
- `md_kill`:
  - In CALC or FIX: go to IDLE next edge; hi/lo unchanged.
  - Kill overrides a same-cycle start or mthi/mtlo.
- Reset mid-operation: immediate IDLE, hi=lo=0.
- Operands are not resampled during CALC; `rs_val`/`rt_val` changes are ignored after accept.

Decomposition:
- Package `alu_ctrl_pkg`:
  - 4-bit ALU op localparams (ALU_ADD…ALU_PASS).
  - 6-bit funct constants (FN_ADD…FN_MTLO).
  - `alu_ctr` class constants.
  - md state enum (IDLE, CALC, FIX).
- One natural sub-module: `md_iter_core`. It holds the datapath registers, counter and FSM, exposing start/kill/done. The top level keeps decode, stall and HI/LO writes.

Test Plan:
- Decode sweep: all 64 `func` values with `alu_ctr`=10, plus `alu_ctr`=00/01/11 → `alu_op` matches table; e.g. 101011→7, 011000→15.
- multu, `rs_val`=0xFFFFFFFF, `rt_val`=0x00000002 → `md_busy` high 33 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
- mult −7×3 (0xFFFFFFF9, 0x3) → hi=0xFFFFFFFF, lo=0xFFFFFFEB. div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 100/0 → after 33 cycles lo=0xFFFFFFFF, hi=0x00000064. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- mflo issued 5 cycles after mult → `md_stall`=1 until the cycle `md_busy` falls, then 0. A second mult while busy stalls and is not accepted.
- `md_kill` in CALC cycle 10 after mthi wrote 0x1234 → busy drops next edge, hi=0x1234 unchanged. `rst_n` pulsed low mid-op → hi=lo=0, busy=0 asynchronously.
